// File: rtl/ahbl_splitter_dflt.sv
// ahbl_splitter_dflt: 1:N AHB-Lite splitter with a built-in default slave.
// The address phase is decoded combinationally and broadcast to every port.
// Only the decoded port sees an active htrans. A registered one-hot data-phase
// select routes the response back to the master. Accesses that hit no port
// go to an internal default slave. That slave returns the two-cycle ERROR
// response, or a zero-wait OKAY when ERR_ON_UNMAPPED is 0.
// Optional feature: define AHBL_SPLITTER_DFLT_ERRCAPT_EN to add sticky capture
// of the first faulting address (ports err_clr / err_valid / err_addr / err_write).
module ahbl_splitter_dflt #(
    parameter int                          N_PORTS         = 2,
    parameter int                          W_ADDR          = 32,
    parameter int                          W_DATA          = 32,
    parameter logic [N_PORTS*W_ADDR-1:0]   ADDR_MAP        = {N_PORTS*W_ADDR{1'b0}},
    parameter logic [N_PORTS*W_ADDR-1:0]   ADDR_MASK       = {N_PORTS*W_ADDR{1'b1}},
    parameter int                          ERR_ON_UNMAPPED = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    // master side
    input  logic                           src_hready,
    output logic                           src_hready_resp,
    output logic                           src_hresp,
    input  logic [W_ADDR-1:0]              src_haddr,
    input  logic                           src_hwrite,
    input  logic [1:0]                     src_htrans,
    input  logic [2:0]                     src_hsize,
    input  logic [2:0]                     src_hburst,
    input  logic [3:0]                     src_hprot,
    input  logic                           src_hmastlock,
    input  logic [W_DATA-1:0]              src_hwdata,
    output logic [W_DATA-1:0]              src_hrdata,
    // slave side, port i packed at [i*W +: W]
    output logic [N_PORTS-1:0]             dst_hready,
    input  logic [N_PORTS-1:0]             dst_hready_resp,
    input  logic [N_PORTS-1:0]             dst_hresp,
    output logic [N_PORTS*W_ADDR-1:0]      dst_haddr,
    output logic [N_PORTS-1:0]             dst_hwrite,
    output logic [N_PORTS*2-1:0]           dst_htrans,
    output logic [N_PORTS*3-1:0]           dst_hsize,
    output logic [N_PORTS*3-1:0]           dst_hburst,
    output logic [N_PORTS*4-1:0]           dst_hprot,
    output logic [N_PORTS-1:0]             dst_hmastlock,
    output logic [N_PORTS*W_DATA-1:0]      dst_hwdata,
    input  logic [N_PORTS*W_DATA-1:0]      dst_hrdata
`ifdef AHBL_SPLITTER_DFLT_ERRCAPT_EN
    ,
    input  logic                           err_clr,
    output logic                           err_valid,
    output logic [W_ADDR-1:0]              err_addr,
    output logic                           err_write
`endif
);

    localparam bit ERR_EN = (ERR_ON_UNMAPPED != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } dflt_state_t;

    // Keep only the lowest set bit so overlapping windows resolve to the lowest port.
    function automatic logic [N_PORTS-1:0] pick_lowest(input logic [N_PORTS-1:0] v);
        logic [N_PORTS-1:0] r;
        logic               found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    logic [N_PORTS-1:0] hit_raw_p0;
    logic [N_PORTS-1:0] hit_p0;
    logic               any_hit_p0;
    logic               accept_p0;
    logic               err_start_p0;
    logic [N_PORTS:0]   dsel_p1;      // [N_PORTS] = default slave, others one-hot per port
    dflt_state_t        state_q;
    dflt_state_t        state_d;
    logic               dflt_ready;
    logic               dflt_resp;

    // ---- address phase (p0): decode and broadcast ----

    // Window match for every port against its base/mask pair.
    always_comb begin
        hit_raw_p0 = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            hit_raw_p0[i] = ((src_haddr & ADDR_MASK[i*W_ADDR +: W_ADDR])
                             == ADDR_MAP[i*W_ADDR +: W_ADDR]);
        end
    end

    assign hit_p0       = pick_lowest(hit_raw_p0);
    assign any_hit_p0   = |hit_raw_p0;
    assign accept_p0    = src_hready & src_htrans[1];
    assign err_start_p0 = ERR_EN & accept_p0 & ~any_hit_p0;

    // Only the decoded port sees the real htrans; all others see IDLE.
    always_comb begin
        dst_htrans = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (hit_p0[i]) begin
                dst_htrans[i*2 +: 2] = src_htrans;
            end
        end
    end

    assign dst_hready    = {N_PORTS{src_hready}};
    assign dst_haddr     = {N_PORTS{src_haddr}};
    assign dst_hwrite    = {N_PORTS{src_hwrite}};
    assign dst_hsize     = {N_PORTS{src_hsize}};
    assign dst_hburst    = {N_PORTS{src_hburst}};
    assign dst_hprot     = {N_PORTS{src_hprot}};
    assign dst_hmastlock = {N_PORTS{src_hmastlock}};
    assign dst_hwdata    = {N_PORTS{src_hwdata}};

    // ---- data phase (p1): select register, default slave, response mux ----

    // Capture which target owns the next data phase; hold it across wait states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsel_p1 <= '0;
        end else if (src_hready) begin
            dsel_p1 <= accept_p0 ? {~any_hit_p0, hit_p0} : '0;
        end
    end

    // Default slave state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Default slave next state: ERR1 always advances; ERR2 may chain into another error.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (err_start_p0) state_d = ST_ERR1;
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = err_start_p0 ? ST_ERR1 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Default slave outputs: ERR1 stalls with ERROR, ERR2 completes with ERROR.
    always_comb begin
        dflt_ready = 1'b1;
        dflt_resp  = 1'b0;
        case (state_q)
            ST_ERR1: begin
                dflt_ready = 1'b0;
                dflt_resp  = 1'b1;
            end
            ST_ERR2: begin
                dflt_ready = 1'b1;
                dflt_resp  = 1'b1;
            end
            default: begin
                dflt_ready = 1'b1;
                dflt_resp  = 1'b0;
            end
        endcase
    end

    // Return path: route the selected port back to the master. With no selection the bus sees an idle OKAY.
    always_comb begin
        src_hready_resp = 1'b1;
        src_hresp       = 1'b0;
        src_hrdata      = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (dsel_p1[i]) begin
                src_hready_resp = dst_hready_resp[i];
                src_hresp       = dst_hresp[i];
                src_hrdata      = dst_hrdata[i*W_DATA +: W_DATA];
            end
        end
        if (dsel_p1[N_PORTS]) begin
            src_hready_resp = dflt_ready;
            src_hresp       = dflt_resp;
        end
    end

`ifdef AHBL_SPLITTER_DFLT_ERRCAPT_EN
    logic err_entry_p0;

    // ERR1 is re-entered from ERR2 as well as from IDLE, so qualify on not already being in ERR1.
    assign err_entry_p0 = err_start_p0 & (state_q != ST_ERR1);

    // Sticky first-fault capture. A clear in the same cycle as a new fault lets that fault in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_write <= 1'b0;
        end else if (err_entry_p0 && (!err_valid || err_clr)) begin
            err_valid <= 1'b1;
            err_addr  <= src_haddr;
            err_write <= src_hwrite;
        end else if (err_clr) begin
            err_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ahbl_splitter_dflt.sv
// Bench for ahbl_splitter_dflt: four ports with simple zero-wait memory slaves,
// plus a second instance with ERR_ON_UNMAPPED=0.
module tb_ahbl_splitter_dflt;

    localparam int NP = 4;
    localparam logic [NP*32-1:0] MAP  = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100, 32'h0000_0000};
    localparam logic [NP*32-1:0] MASK = {4{32'hffff_ff00}};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A (ERROR on unmapped) ----------------
    logic              a_hready_resp, a_hresp;
    logic [31:0]       a_haddr, a_hwdata, a_hrdata;
    logic              a_hwrite, a_hmastlock;
    logic [1:0]        a_htrans;
    logic [2:0]        a_hsize, a_hburst;
    logic [3:0]        a_hprot;
    logic [NP-1:0]     a_dst_hready, a_dst_hwrite, a_dst_hmastlock;
    logic [NP*32-1:0]  a_dst_haddr, a_dst_hwdata, a_dst_hrdata;
    logic [NP*2-1:0]   a_dst_htrans;
    logic [NP*3-1:0]   a_dst_hsize, a_dst_hburst;
    logic [NP*4-1:0]   a_dst_hprot;
`ifdef AHBL_SPLITTER_DFLT_ERRCAPT_EN
    logic              a_err_clr, a_err_valid, a_err_write;
    logic [31:0]       a_err_addr;
`endif

    ahbl_splitter_dflt #(
        .N_PORTS(NP), .W_ADDR(32), .W_DATA(32),
        .ADDR_MAP(MAP), .ADDR_MASK(MASK), .ERR_ON_UNMAPPED(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .src_hready(a_hready_resp), .src_hready_resp(a_hready_resp), .src_hresp(a_hresp),
        .src_haddr(a_haddr), .src_hwrite(a_hwrite), .src_htrans(a_htrans),
        .src_hsize(a_hsize), .src_hburst(a_hburst), .src_hprot(a_hprot),
        .src_hmastlock(a_hmastlock), .src_hwdata(a_hwdata), .src_hrdata(a_hrdata),
        .dst_hready(a_dst_hready), .dst_hready_resp({NP{1'b1}}), .dst_hresp({NP{1'b0}}),
        .dst_haddr(a_dst_haddr), .dst_hwrite(a_dst_hwrite), .dst_htrans(a_dst_htrans),
        .dst_hsize(a_dst_hsize), .dst_hburst(a_dst_hburst), .dst_hprot(a_dst_hprot),
        .dst_hmastlock(a_dst_hmastlock), .dst_hwdata(a_dst_hwdata), .dst_hrdata(a_dst_hrdata)
`ifdef AHBL_SPLITTER_DFLT_ERRCAPT_EN
        ,
        .err_clr(a_err_clr), .err_valid(a_err_valid), .err_addr(a_err_addr), .err_write(a_err_write)
`endif
    );

    // Zero-wait memory slaves, 64 words each.
    logic [31:0] mem [NP][64];
    logic [NP-1:0] ph_v = '0;
    logic [NP-1:0] ph_w = '0;
    logic [5:0]    ph_idx [NP];

    always @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (a_dst_hready[p]) begin
                if (ph_v[p] && ph_w[p]) mem[p][ph_idx[p]] <= a_dst_hwdata[p*32 +: 32];
                ph_v[p]   <= a_dst_htrans[p*2+1];
                ph_w[p]   <= a_dst_hwrite[p];
                ph_idx[p] <= a_dst_haddr[p*32+2 +: 6];
            end
        end
    end

    always_comb begin
        a_dst_hrdata = '0;
        for (int p = 0; p < NP; p++) a_dst_hrdata[p*32 +: 32] = mem[p][ph_idx[p]];
    end

    // ---------------- instance B (OKAY on unmapped) ----------------
    logic              b_hready_resp, b_hresp;
    logic [31:0]       b_haddr, b_hrdata;
    logic [1:0]        b_htrans;
    logic [NP-1:0]     b_dst_hready, b_dst_hwrite, b_dst_hmastlock;
    logic [NP*32-1:0]  b_dst_haddr, b_dst_hwdata;
    logic [NP*2-1:0]   b_dst_htrans;
    logic [NP*3-1:0]   b_dst_hsize, b_dst_hburst;
    logic [NP*4-1:0]   b_dst_hprot;
`ifdef AHBL_SPLITTER_DFLT_ERRCAPT_EN
    logic              b_err_valid, b_err_write;
    logic [31:0]       b_err_addr;
`endif

    ahbl_splitter_dflt #(
        .N_PORTS(NP), .W_ADDR(32), .W_DATA(32),
        .ADDR_MAP(MAP), .ADDR_MASK(MASK), .ERR_ON_UNMAPPED(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .src_hready(b_hready_resp), .src_hready_resp(b_hready_resp), .src_hresp(b_hresp),
        .src_haddr(b_haddr), .src_hwrite(1'b0), .src_htrans(b_htrans),
        .src_hsize(3'b010), .src_hburst(3'b000), .src_hprot(4'b0011),
        .src_hmastlock(1'b0), .src_hwdata(32'h0), .src_hrdata(b_hrdata),
        .dst_hready(b_dst_hready), .dst_hready_resp({NP{1'b1}}), .dst_hresp({NP{1'b0}}),
        .dst_haddr(b_dst_haddr), .dst_hwrite(b_dst_hwrite), .dst_htrans(b_dst_htrans),
        .dst_hsize(b_dst_hsize), .dst_hburst(b_dst_hburst), .dst_hprot(b_dst_hprot),
        .dst_hmastlock(b_dst_hmastlock), .dst_hwdata(b_dst_hwdata),
        .dst_hrdata({32'hB0B0_0003, 32'hB0B0_0002, 32'hB0B0_0001, 32'hB0B0_0000})
`ifdef AHBL_SPLITTER_DFLT_ERRCAPT_EN
        ,
        .err_clr(1'b0), .err_valid(b_err_valid), .err_addr(b_err_addr), .err_write(b_err_write)
`endif
    );

    // ---------------- helpers ----------------
    logic [31:0] ref_mem [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Single non-pipelined transfer on instance A.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic resp_first,
                        output logic resp_last, output int waits, output logic [7:0] htr);
        @(negedge clk);
        a_haddr  = addr;
        a_hwrite = wr;
        a_htrans = 2'b10;
        #1 htr = a_dst_htrans;
        @(negedge clk);
        a_htrans   = 2'b00;
        a_hwdata   = wdata;
        waits      = 0;
        resp_first = a_hresp;
        while (!a_hready_resp && waits < 16) begin
            waits++;
            @(negedge clk);
        end
        resp_last = a_hresp;
        rdata     = a_hrdata;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        chk_rd;
        logic        exp_resp;
        int          exp_waits;
        logic [7:0]  exp_htr;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [31:0] rd;
        logic        r1, rl;
        int          w;
        logic [7:0]  ht;
        int          resp_errs;

        rst_n = 1'b0;
        a_haddr = '0; a_hwrite = 1'b0; a_htrans = 2'b00; a_hsize = 3'b010;
        a_hburst = 3'b000; a_hprot = 4'b0011; a_hmastlock = 1'b0; a_hwdata = '0;
        b_haddr = '0; b_htrans = 2'b00;
`ifdef AHBL_SPLITTER_DFLT_ERRCAPT_EN
        a_err_clr = 1'b0;
`endif

        // reset state
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, a_hready_resp}, 32'd1);
        check("rst_resp",  {31'b0, a_hresp},       32'd0);
        check("rst_rdata", a_hrdata,               32'd0);
        rst_n = 1'b1;

        // fill all four ports and read everything back
        resp_errs = 0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = $urandom;
            xfer(i * 4, 1'b1, ref_mem[i], rd, r1, rl, w, ht);
            if (rl !== 1'b0 || w != 0) resp_errs++;
        end
        for (int i = 0; i < 256; i++) begin
            xfer(i * 4, 1'b0, 32'h0, rd, r1, rl, w, ht);
            if (rl !== 1'b0 || w != 0) resp_errs++;
            check($sformatf("fill_rd[%0d]", i), rd, ref_mem[i]);
        end
        check("fill_resp_waits", resp_errs, 0);

        // directed vector table
        vecs[0]  = '{32'h010, 1'b1, 32'h1111_1111, 32'h0,          1'b0, 1'b0, 0, 8'h02};
        vecs[1]  = '{32'h114, 1'b1, 32'h2222_2222, 32'h0,          1'b0, 1'b0, 0, 8'h08};
        vecs[2]  = '{32'h218, 1'b1, 32'h3333_3333, 32'h0,          1'b0, 1'b0, 0, 8'h20};
        vecs[3]  = '{32'h31c, 1'b1, 32'h4444_4444, 32'h0,          1'b0, 1'b0, 0, 8'h80};
        vecs[4]  = '{32'h010, 1'b0, 32'h0,         32'h1111_1111,  1'b1, 1'b0, 0, 8'h02};
        vecs[5]  = '{32'h114, 1'b0, 32'h0,         32'h2222_2222,  1'b1, 1'b0, 0, 8'h08};
        vecs[6]  = '{32'h218, 1'b0, 32'h0,         32'h3333_3333,  1'b1, 1'b0, 0, 8'h20};
        vecs[7]  = '{32'h31c, 1'b0, 32'h0,         32'h4444_4444,  1'b1, 1'b0, 0, 8'h80};
        vecs[8]  = '{32'h400, 1'b0, 32'h0,         32'h0,          1'b1, 1'b1, 1, 8'h00};
        vecs[9]  = '{32'h500, 1'b1, 32'hdead_beef, 32'h0,          1'b1, 1'b1, 1, 8'h00};
        vecs[10] = '{32'h004, 1'b1, 32'h5555_5555, 32'h0,          1'b0, 1'b0, 0, 8'h02};
        vecs[11] = '{32'h004, 1'b0, 32'h0,         32'h5555_5555,  1'b1, 1'b0, 0, 8'h02};
        vecs[12] = '{32'hffc, 1'b0, 32'h0,         32'h0,          1'b1, 1'b1, 1, 8'h00};
        vecs[13] = '{32'h3fc, 1'b1, 32'h6666_6666, 32'h0,          1'b0, 1'b0, 0, 8'h80};
        vecs[14] = '{32'h3fc, 1'b0, 32'h0,         32'h6666_6666,  1'b1, 1'b0, 0, 8'h80};
        vecs[15] = '{32'h1_0100, 1'b0, 32'h0,      32'h0,          1'b1, 1'b1, 1, 8'h00};

        for (int v = 0; v < 16; v++) begin
            xfer(vecs[v].addr, vecs[v].wr, vecs[v].wdata, rd, r1, rl, w, ht);
            if (vecs[v].wr && vecs[v].addr < 32'h400) ref_mem[vecs[v].addr[9:2]] = vecs[v].wdata;
            check($sformatf("vec%0d_htrans", v), {24'b0, ht}, {24'b0, vecs[v].exp_htr});
            check($sformatf("vec%0d_waits", v), w, vecs[v].exp_waits);
            check($sformatf("vec%0d_resp", v), {31'b0, rl}, {31'b0, vecs[v].exp_resp});
            if (vecs[v].exp_waits > 0) check($sformatf("vec%0d_resp1", v), {31'b0, r1}, 32'd1);
            if (vecs[v].chk_rd) check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
        end

        // pipelined write to port0 followed directly by read from port1
        @(negedge clk);
        a_haddr = 32'h0fc; a_hwrite = 1'b1; a_htrans = 2'b10;
        @(negedge clk);
        check("pipe_wr_ready", {31'b0, a_hready_resp}, 32'd1);
        a_hwdata = 32'hCAFE_00FC;
        a_haddr = 32'h100; a_hwrite = 1'b0; a_htrans = 2'b10;
        #1 check("pipe_rd_htrans", {24'b0, a_dst_htrans}, 32'h08);
        @(negedge clk);
        check("pipe_rd_ready", {31'b0, a_hready_resp}, 32'd1);
        check("pipe_rd_resp",  {31'b0, a_hresp},       32'd0);
        check("pipe_rd_rdata", a_hrdata, ref_mem[64]);
        a_htrans = 2'b00;
        ref_mem[63] = 32'hCAFE_00FC;
        xfer(32'h0fc, 1'b0, 32'h0, rd, r1, rl, w, ht);
        check("pipe_wr_readback", rd, 32'hCAFE_00FC);

        // unmapped write, then a mapped write issued in ERR2
        @(negedge clk);
        a_haddr = 32'h500; a_hwrite = 1'b1; a_htrans = 2'b10;
        @(negedge clk);
        check("e2o_err1", {30'b0, a_hready_resp, a_hresp}, 32'b01);
        a_htrans = 2'b00;
        @(negedge clk);
        check("e2o_err2", {30'b0, a_hready_resp, a_hresp}, 32'b11);
        a_haddr = 32'h004; a_hwrite = 1'b1; a_htrans = 2'b10;
        @(negedge clk);
        check("e2o_okay", {30'b0, a_hready_resp, a_hresp}, 32'b10);
        a_hwdata = 32'h0BAD_F00D; a_htrans = 2'b00;
        xfer(32'h004, 1'b0, 32'h0, rd, r1, rl, w, ht);
        check("e2o_readback", rd, 32'h0BAD_F00D);

        // back-to-back errors: the transfer held during ERR1 is accepted in ERR2
        @(negedge clk);
        a_haddr = 32'h400; a_hwrite = 1'b0; a_htrans = 2'b10;
        @(negedge clk);
        check("b2b_err1a", {30'b0, a_hready_resp, a_hresp}, 32'b01);
        a_haddr = 32'h600;
        @(negedge clk);
        check("b2b_err2a", {30'b0, a_hready_resp, a_hresp}, 32'b11);
        @(negedge clk);
        check("b2b_err1b", {30'b0, a_hready_resp, a_hresp}, 32'b01);
        a_htrans = 2'b00;
        @(negedge clk);
        check("b2b_err2b", {30'b0, a_hready_resp, a_hresp}, 32'b11);
        @(negedge clk);
        check("b2b_idle",  {30'b0, a_hready_resp, a_hresp}, 32'b10);

        // reset in the middle of ERR1 takes effect without a clock edge
        @(negedge clk);
        a_haddr = 32'h400; a_hwrite = 1'b0; a_htrans = 2'b10;
        @(negedge clk);
        check("rst_mid_err1", {30'b0, a_hready_resp, a_hresp}, 32'b01);
        a_htrans = 2'b00;
        rst_n = 1'b0;
        #1;
        check("rst_mid_resp", {30'b0, a_hready_resp, a_hresp}, 32'b10);
        check("rst_mid_rdata", a_hrdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef AHBL_SPLITTER_DFLT_ERRCAPT_EN
        check("cap_rst_valid", {31'b0, a_err_valid}, 32'd0);
        check("cap_rst_addr",  a_err_addr,           32'd0);
        check("cap_rst_write", {31'b0, a_err_write}, 32'd0);
        xfer(32'h500, 1'b1, 32'h0, rd, r1, rl, w, ht);
        xfer(32'h600, 1'b0, 32'h0, rd, r1, rl, w, ht);
        check("cap_valid", {31'b0, a_err_valid}, 32'd1);
        check("cap_addr",  a_err_addr,           32'h500);
        check("cap_write", {31'b0, a_err_write}, 32'd1);
        @(negedge clk);
        a_err_clr = 1'b1;
        @(negedge clk);
        a_err_clr = 1'b0;
        check("cap_clr", {31'b0, a_err_valid}, 32'd0);
        xfer(32'h500, 1'b1, 32'h0, rd, r1, rl, w, ht);
        check("cap_again", a_err_addr, 32'h500);
        @(negedge clk);
        a_haddr = 32'h700; a_hwrite = 1'b0; a_htrans = 2'b10; a_err_clr = 1'b1;
        @(negedge clk);
        a_err_clr = 1'b0; a_htrans = 2'b00;
        check("cap_clrnew_valid", {31'b0, a_err_valid}, 32'd1);
        check("cap_clrnew_addr",  a_err_addr,           32'h700);
        check("cap_clrnew_write", {31'b0, a_err_write}, 32'd0);
        repeat (2) @(negedge clk);
`endif

        // ERR_ON_UNMAPPED=0 instance: unmapped read is a zero-wait OKAY with zero data
        @(negedge clk);
        b_haddr = 32'h400; b_htrans = 2'b10;
        #1 check("okay_htrans", {24'b0, b_dst_htrans}, 32'h00);
        @(negedge clk);
        check("okay_resp",  {30'b0, b_hready_resp, b_hresp}, 32'b10);
        check("okay_rdata", b_hrdata, 32'd0);
        b_haddr = 32'h200;
        @(negedge clk);
        check("okay_mapped_rdata", b_hrdata, 32'hB0B0_0002);
        b_htrans = 2'b00;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
